// File: rtl/ex_div_pkg.sv
// Shared widths, control encodings and FSM states for the execute-stage divider.
// Signed support is selected at build time by the EX_DIV_SIGNED_EN macro.
package ex_div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic RstEnable         = 1'b1;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [5:0] DivIters = 6'd32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic [RegBus-1:0] cond_neg(input logic [RegBus-1:0] v, input logic neg);
    return neg ? ({RegBus{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/ex_div_div_step.sv
// One radix-2 restoring iteration on the {remainder, dividend/quotient} working register.
// Working register layout: [64:32] partial remainder, [31:0] dividend bits shifting into quotient bits.
module div_step
  import ex_div_pkg::*;
(
  input  logic [DoubleRegBus:0] work_i,
  input  logic [RegBus-1:0]     divisor_i,
  output logic [DoubleRegBus:0] work_o
);

  logic [RegBus:0]   shifted;
  logic [RegBus+1:0] trial;
  logic              unused_msb;

  // The remainder stays below the divisor, so its top bit is always clear.
  assign unused_msb = work_i[DoubleRegBus];
  assign shifted    = {work_i[DoubleRegBus-1:RegBus], work_i[RegBus-1]};
  assign trial      = {1'b0, shifted} - {2'b00, divisor_i};

  assign work_o = trial[RegBus+1]
                ? {shifted, work_i[RegBus-2:0], 1'b0}
                : {trial[RegBus:0], work_i[RegBus-2:0], 1'b1};

endmodule

// File: rtl/ex_div.sv
// Multi-cycle 32-bit restoring divider returning {remainder, quotient} for HI/LO.
// Define EX_DIV_SIGNED_EN to honour signed_div_i; otherwise every operation is unsigned.
module ex_div
  import ex_div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e              state_reg, state_next;
  logic [5:0]              cnt_reg, cnt_next;
  logic [DoubleRegBus:0]   work_reg, work_next, step_work;
  logic [RegBus-1:0]       divisor_reg, divisor_next;
  logic [DoubleRegBus-1:0] result_reg, result_next;
  logic                    ready_reg, ready_next;

  logic [RegBus-1:0] op1_mag, op2_mag, quot_fix, rem_fix;
  logic              load;

  assign load = (state_reg == DivFree) && (start_i == DivStart) && !annul_i
             && (opdata2_i != '0);

`ifdef EX_DIV_SIGNED_EN
  logic op1_neg, op2_neg;
  logic dividend_neg_reg, divisor_neg_reg;

  assign op1_neg  = signed_div_i & opdata1_i[RegBus-1];
  assign op2_neg  = signed_div_i & opdata2_i[RegBus-1];
  assign op1_mag  = cond_neg(opdata1_i, op1_neg);
  assign op2_mag  = cond_neg(opdata2_i, op2_neg);
  assign quot_fix = cond_neg(work_reg[RegBus-1:0], dividend_neg_reg ^ divisor_neg_reg);
  assign rem_fix  = cond_neg(work_reg[DoubleRegBus-1:RegBus], dividend_neg_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      dividend_neg_reg <= 1'b0;
      divisor_neg_reg  <= 1'b0;
    end else if (load) begin
      dividend_neg_reg <= op1_neg;
      divisor_neg_reg  <= op2_neg;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_div_i;
  assign op1_mag       = opdata1_i;
  assign op2_mag       = opdata2_i;
  assign quot_fix      = work_reg[RegBus-1:0];
  assign rem_fix       = work_reg[DoubleRegBus-1:RegBus];
`endif

  div_step u_div_step (
    .work_i    (work_reg),
    .divisor_i (divisor_reg),
    .work_o    (step_work)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_reg   <= DivFree;
      cnt_reg     <= '0;
      work_reg    <= '0;
      divisor_reg <= '0;
      result_reg  <= '0;
      ready_reg   <= DivResultNotReady;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      work_reg    <= work_next;
      divisor_reg <= divisor_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    work_next    = work_reg;
    divisor_next = divisor_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;
    case (state_reg)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = DivByZero;
          end else begin
            state_next   = DivOn;
            cnt_next     = '0;
            work_next    = {{(RegBus+1){1'b0}}, op1_mag};
            divisor_next = op2_mag;
          end
        end
      end
      DivByZero: begin
        state_next  = DivEnd;
        result_next = '0;
        ready_next  = DivResultReady;
      end
      DivOn: begin
        // Annul wins over both iteration and completion.
        if (annul_i) begin
          state_next = DivFree;
          cnt_next   = '0;
        end else if (cnt_reg != DivIters) begin
          work_next = step_work;
          cnt_next  = cnt_reg + 6'd1;
        end else begin
          state_next  = DivEnd;
          result_next = {rem_fix, quot_fix};
          ready_next  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_next  = DivFree;
          result_next = '0;
          ready_next  = DivResultNotReady;
        end
      end
      default: state_next = DivFree;
    endcase
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus randomized operands against
// an arithmetic reference model; follows EX_DIV_SIGNED_EN the same way the design does.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: divide magnitudes, then quotient sign = sign(a)^sign(b), remainder sign = sign(a).
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    if (b == 32'd0) return 64'd0;
`ifdef EX_DIV_SIGNED_EN
    na = s & a[31];
    nb = s & b[31];
`else
    na = 1'b0 & s;
    nb = 1'b0;
`endif
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    return {r, q};
  endfunction

  // Full transaction: accept, measure latency, check result, hold, release.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int hold, input logic [63:0] exp);
    int   n;
    logic pre;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1; annul = 1'b0;
    @(posedge clk);
    @(negedge clk);
    opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
    n = 0; pre = 1'b0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
      if (result != 64'd0) pre = 1'b1;
    end
    $display("div a=%h b=%h s=%0d -> res=%h rdy=%0d edges=%0d", a, b, s, result, ready, n);
    chk("latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    chk("result", result, exp);
    chk("early_out", 64'(pre), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rdy", 64'(ready), 64'd1);
      chk("hold_res", result, exp);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("drop_rdy", 64'(ready), 64'd0);
    chk("drop_res", result, 64'd0);
  endtask

  // Watches a number of edges and reports whether ready ever rose.
  task automatic watch_no_ready(input string tag, input int edges);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < edges; i++) begin
      @(posedge clk); #1;
      if (ready || result != 64'd0) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          n;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    #12;
    chk("rst_rdy", 64'(ready), 64'd0);
    chk("rst_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div(32'd100, 32'd7, 1'b0, 2, 64'h00000002_0000000E);
`ifdef EX_DIV_SIGNED_EN
    do_div(32'hFFFFFFF9, 32'h2, 1'b1, 0, 64'hFFFFFFFF_FFFFFFFD);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 64'h00000000_80000000);
`else
    do_div(32'hFFFFFFF9, 32'h2, 1'b1, 0, 64'h00000001_7FFFFFFC);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 64'h80000000_00000000);
`endif
    do_div(32'hFFFFFFF9, 32'h2, 1'b0, 0, 64'h00000001_7FFFFFFC);
    do_div(32'd12345, 32'd0, 1'b0, 1, 64'd0);
    do_div(32'h80000000, 32'd0, 1'b1, 0, 64'd0);

    // Annul at cnt=10, then a fresh request with full latency.
    @(negedge clk);
    opdata1 = 32'd50; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    chk("annul_rdy", 64'(ready), 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    watch_no_ready("annul_quiet", 40);
    do_div(32'd9, 32'd3, 1'b0, 0, 64'h00000000_00000003);

    // Annul together with start in the idle state: not accepted (zero divisor would finish fast).
    @(negedge clk);
    opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
    watch_no_ready("annul_start", 5);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    @(posedge clk);

    // Asynchronous reset mid-operation at cnt=20.
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1; start = 1'b0;
    #1;
    chk("arst_mid_rdy", 64'(ready), 64'd0);
    chk("arst_mid_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_ready("arst_mid_quiet", 40);

    // Asynchronous reset while a result is held: outputs clear before any edge.
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
    end
    chk("pre_arst_res", result, 64'h00000002_0000000E);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_end_rdy", 64'(ready), 64'd0);
    chk("arst_end_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);

    // Randomized operands against the reference model.
    for (int t = 0; t < 25; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      do_div(a, b, s, $urandom_range(0, 3), ref_div(a, b, s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
